// File: rtl/mic_req_arb.sv
// Packet-granular round-robin arbiter for MIC masters sharing one slave; responses are
// steered back to their masters via a grant-order routing FIFO. Option: MIC_ARB_STATS_EN.
module mic_req_arb #(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ*64-1:0]   I_TDATA,
  input  logic [NUM_REQ-1:0]      I_TVALID,
  output logic [NUM_REQ-1:0]      I_TREADY,
  input  logic [NUM_REQ-1:0]      I_TLAST,
  output logic [63:0]             O_TDATA,
  output logic                    O_TVALID,
  input  logic                    O_TREADY,
  output logic                    O_TLAST,
  input  logic [63:0]             R_I_TDATA,
  input  logic                    R_I_TVALID,
  output logic                    R_I_TREADY,
  input  logic                    R_I_TLAST,
  output logic [NUM_REQ*64-1:0]   R_O_TDATA,
  output logic [NUM_REQ-1:0]      R_O_TVALID,
  input  logic [NUM_REQ-1:0]      R_O_TREADY,
  output logic [NUM_REQ-1:0]      R_O_TLAST
`ifdef MIC_ARB_STATS_EN
  ,
  input  logic                    stat_clear,
  output logic [NUM_REQ*16-1:0]   STAT_PKTS
`endif
);

  localparam int unsigned GW    = $clog2(NUM_REQ);
  localparam int unsigned AW    = $clog2(OUTSTANDING);
  localparam int unsigned PTR_W = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    FWD  = 1'b1
  } state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [GW-1:0]     last_grant;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  fifo_cnt;
  logic [GW-1:0]     mem [OUTSTANDING];
  logic [GW-1:0]     head;
  logic              fifo_empty;
  logic              fifo_full;

  logic              arb_found;
  logic [GW-1:0]     arb_pick;
  int unsigned       arb_idx;
  logic              sel_valid;
  logic              sel_last;
  logic [63:0]       sel_data;
  logic              fwd;
  logic              pkt_done;
  logic              push;
  logic              pop;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_cnt == PTR_W'(OUTSTANDING));
  assign head       = mem[rd_ptr[AW-1:0]];

  // First valid port after last_grant, wrapping modulo NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_idx   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      arb_idx = 32'(last_grant) + i;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (!arb_found && I_TVALID[GW'(arb_idx)]) begin
        arb_found = 1'b1;
        arb_pick  = GW'(arb_idx);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant == GW'(n)) begin
        sel_valid = I_TVALID[n];
        sel_last  = I_TLAST[n];
        sel_data  = I_TDATA[n*64 +: 64];
      end
    end
  end

  assign fwd      = (state == FWD);
  assign O_TVALID = fwd & sel_valid;
  assign O_TLAST  = fwd & sel_last;
  assign O_TDATA  = fwd ? sel_data : 64'h0;
  assign pkt_done = O_TVALID & O_TREADY & O_TLAST;

  always_comb begin
    I_TREADY = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      I_TREADY[n] = fwd && (grant == GW'(n)) && O_TREADY;
    end
  end

  // Response steering: only the master at the FIFO head sees the response stream.
  always_comb begin
    R_O_TVALID = '0;
    R_O_TLAST  = '0;
    R_I_TREADY = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (!fifo_empty && (head == GW'(n))) begin
        R_O_TVALID[n] = R_I_TVALID;
        R_O_TLAST[n]  = R_I_TLAST;
        R_I_TREADY    = R_O_TREADY[n];
      end
    end
  end

  assign R_O_TDATA = {NUM_REQ{R_I_TDATA}};
  assign pop       = R_I_TVALID & R_I_TREADY & R_I_TLAST;
  // A same-cycle pop frees the slot, so a full FIFO may still accept a grant.
  assign push      = (state == IDLE) & arb_found & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            grant <= arb_pick;
            state <= FWD;
          end
        end
        FWD: begin
          if (pkt_done) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= arb_pick;
  end

`ifdef MIC_ARB_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  // Clear wins over a same-cycle packet completion.
  always_ff @(posedge clk) begin
    for (int n = 0; n < NUM_REQ; n++) begin
      if (!reset || stat_clear) begin
        stat_cnt[n] <= '0;
      end else if (pkt_done && (grant == GW'(n))) begin
        stat_cnt[n] <= stat_cnt[n] + 16'd1;
      end
    end
  end

  always_comb begin
    STAT_PKTS = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      STAT_PKTS[n*16 +: 16] = stat_cnt[n];
    end
  end
`endif

endmodule
